// File: rtl/uart_txd.sv
// 8N1 UART transmitter with a one-entry holding buffer and optional even parity.
// Bytes queued during a frame go out back-to-back with no idle gap.
module uart_txd #(
    parameter int SYS_CLK   = 40_000,
    parameter int BPS       = 1000,
    parameter int BPS_CNT   = SYS_CLK / BPS,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic       clk_40k,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_vld,
    output logic       din_rdy,
    output logic       bit_out,
    output logic       busy,
    output logic       tx_done
);
    localparam int CNT_W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic [7:0]       buf_data;
    logic             buf_full;
    logic             bit_end;
    logic             accept;
    logic             load;
    logic             bit_out_nxt;
    logic             tx_done_nxt;

    assign din_rdy = ~buf_full;
    assign accept  = din_vld & ~buf_full;

    always_ff @(posedge clk_40k) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_idx_nxt  = bit_idx;
        baud_cnt_nxt = '0;
        load         = 1'b0;
        tx_done_nxt  = 1'b0;
        bit_end      = (baud_cnt == CNT_MAX);

        if (state != IDLE) begin
            baud_cnt_nxt = bit_end ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (buf_full) begin
                    load      = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        if (PARITY_EN) begin
                            state_nxt = PARITY;
                        end else begin
                            state_nxt = STOP;
                        end
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_done_nxt = 1'b1;
                    if (buf_full) begin
                        load      = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        shift_nxt = load ? buf_data : shift;

        // Line level is derived from the next state so bit_out stays a plain register.
        case (state_nxt)
            START:   bit_out_nxt = 1'b0;
            DATA:    bit_out_nxt = shift_nxt[bit_idx_nxt];
            PARITY:  bit_out_nxt = ^shift_nxt;
            default: bit_out_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_40k) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            buf_data <= '0;
            buf_full <= 1'b0;
            bit_out  <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shift    <= shift_nxt;
            if (accept) begin
                buf_data <= din;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end
            bit_out <= bit_out_nxt;
            busy    <= (state_nxt != IDLE);
            tx_done <= tx_done_nxt;
        end
    end
endmodule

// File: tb/tb_uart_txd.sv
// Bench for uart_txd: three instances (default, parity, 2000 baud) checked against
// a per-instance line decoder fed from a queue of accepted bytes.
`timescale 1ns/1ps
module tb_uart_txd;
    logic clk_40k = 1'b0;
    always #5 clk_40k = ~clk_40k;

    logic [7:0] din_a  [3];
    logic       vld_a  [3];
    logic       rst_a  [3];
    logic       rdy_a  [3];
    logic       bo_a   [3];
    logic       busy_a [3];
    logic       done_a [3];

    uart_txd dut0 (
        .clk_40k(clk_40k), .rst(rst_a[0]), .din(din_a[0]), .din_vld(vld_a[0]),
        .din_rdy(rdy_a[0]), .bit_out(bo_a[0]), .busy(busy_a[0]), .tx_done(done_a[0])
    );
    uart_txd #(.PARITY_EN(1'b1)) dut1 (
        .clk_40k(clk_40k), .rst(rst_a[1]), .din(din_a[1]), .din_vld(vld_a[1]),
        .din_rdy(rdy_a[1]), .bit_out(bo_a[1]), .busy(busy_a[1]), .tx_done(done_a[1])
    );
    uart_txd #(.BPS(2000)) dut2 (
        .clk_40k(clk_40k), .rst(rst_a[2]), .din(din_a[2]), .din_vld(vld_a[2]),
        .din_rdy(rdy_a[2]), .bit_out(bo_a[2]), .busy(busy_a[2]), .tx_done(done_a[2])
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rst_cnt [3] = '{0, 0, 0};
    int st_log  [3][32];
    int dn_log  [3][32];
    int st_n    [3];
    int dn_n    [3];
    int spur    [3];
    bit mon_go = 1'b0;
    int acc_cyc;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always @(posedge clk_40k) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (rst_a[i]) rst_cnt[i] <= rst_cnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] d);
        case (idx)
            0:       q0.push_back(d);
            1:       q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic pop(input int idx, output logic [7:0] d, output bit ok);
        ok = 1'b1;
        d  = '0;
        case (idx)
            0:       if (q0.size() > 0) d = q0.pop_front(); else ok = 1'b0;
            1:       if (q1.size() > 0) d = q1.pop_front(); else ok = 1'b0;
            default: if (q2.size() > 0) d = q2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    function automatic int qsize(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Decodes the line every cycle against the expected frame of the oldest queued byte.
    task automatic monitor(input int idx, input int cnt, input int nbits);
        logic [10:0] fr;
        logic [7:0]  d;
        bit          ok;
        bit          active;
        bit          bad;
        int          pos;
        int          seen_rst;
        active = 1'b0;
        bad    = 1'b0;
        pos    = 0;
        fr     = '1;
        d      = '0;
        wait (mon_go);
        seen_rst = rst_cnt[idx];
        forever begin
            @(negedge clk_40k);
            if (rst_cnt[idx] != seen_rst) begin
                seen_rst = rst_cnt[idx];
                active   = 1'b0;
                pos      = 0;
                bad      = 1'b0;
                continue;
            end
            if (active && pos == nbits * cnt) begin
                active = 1'b0;
                chk($sformatf("tx_done dut%0d", idx), 32'(done_a[idx]), 32'd1);
                if (dn_n[idx] < 32) dn_log[idx][dn_n[idx]] = cyc;
                dn_n[idx]++;
            end else if (done_a[idx] !== 1'b0) begin
                spur[idx]++;
            end
            if (!active && bo_a[idx] === 1'b0) begin
                pop(idx, d, ok);
                chk($sformatf("frame expected dut%0d", idx), 32'(ok), 32'd1);
                fr = '1;
                fr[0] = 1'b0;
                fr[8:1] = d;
                if (nbits == 11) fr[9] = ^d;
                active = 1'b1;
                pos    = 0;
                bad    = 1'b0;
                if (st_n[idx] < 32) st_log[idx][st_n[idx]] = cyc;
                st_n[idx]++;
            end
            if (active) begin
                if (bo_a[idx] !== fr[pos / cnt] || busy_a[idx] !== 1'b1) bad = 1'b1;
                pos++;
                if (pos % cnt == 0) begin
                    chk($sformatf("dut%0d byte %02h bit %0d wrong", idx, d, pos / cnt - 1),
                        32'(bad), 32'd0);
                    bad = 1'b0;
                end
            end else if (bo_a[idx] !== 1'b1 || busy_a[idx] !== 1'b0) begin
                spur[idx]++;
            end
        end
    endtask

    initial monitor(0, 40, 10);
    initial monitor(1, 40, 11);
    initial monitor(2, 20, 10);

    task automatic send(input int idx, input logic [7:0] d);
        int n = 0;
        din_a[idx] = d;
        vld_a[idx] = 1'b1;
        while (rdy_a[idx] !== 1'b1 && n < 2000) begin
            @(negedge clk_40k);
            n++;
        end
        chk($sformatf("send timeout dut%0d", idx), 32'(n < 2000), 32'd1);
        push(idx, d);
        @(negedge clk_40k);
        acc_cyc    = cyc;
        vld_a[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx, input int target, input int budget);
        int n = 0;
        while (dn_n[idx] < target && n < budget) begin
            @(negedge clk_40k);
            n++;
        end
        chk($sformatf("tx_done timeout dut%0d", idx), 32'(dn_n[idx] >= target), 32'd1);
    endtask

    initial begin
        int s0;
        int d0;
        int nacc;
        for (int i = 0; i < 3; i++) begin
            rst_a[i] = 1'b1;
            vld_a[i] = 1'b0;
            din_a[i] = '0;
        end
        repeat (3) @(negedge clk_40k);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset bit_out dut%0d", i), 32'(bo_a[i]), 32'd1);
            chk($sformatf("reset busy dut%0d", i), 32'(busy_a[i]), 32'd0);
            chk($sformatf("reset tx_done dut%0d", i), 32'(done_a[i]), 32'd0);
            chk($sformatf("reset din_rdy dut%0d", i), 32'(rdy_a[i]), 32'd1);
            rst_a[i] = 1'b0;
        end
        mon_go = 1'b1;
        @(negedge clk_40k);

        // single byte: latency and frame length
        send(0, 8'hA5);
        wait_done(0, 1, 600);
        chk("t1 start latency", st_log[0][0], acc_cyc + 1);
        chk("t1 frame length", dn_log[0][0] - st_log[0][0], 400);

        // buffered second byte goes out back-to-back
        repeat (5) @(negedge clk_40k);
        s0 = st_n[0];
        d0 = dn_n[0];
        send(0, 8'h00);
        send(0, 8'hFF);
        chk("t2 din_rdy after 2nd accept", 32'(rdy_a[0]), 32'd0);
        repeat (100) @(negedge clk_40k);
        chk("t2 din_rdy mid-frame", 32'(rdy_a[0]), 32'd0);
        wait_done(0, d0 + 2, 1200);
        chk("t2 zero idle gap", st_log[0][s0 + 1], dn_log[0][d0]);
        chk("t2 tx_done spacing", dn_log[0][d0 + 1] - dn_log[0][d0], 400);

        // parity frames
        send(1, 8'h07);
        wait_done(1, 1, 700);
        chk("t3 parity frame length", dn_log[1][0] - st_log[1][0], 440);
        send(1, 8'h03);
        wait_done(1, 2, 700);
        chk("t3 second parity frame length", dn_log[1][1] - st_log[1][1], 440);

        // reset during D3 with a byte buffered
        repeat (5) @(negedge clk_40k);
        s0 = st_n[0];
        d0 = dn_n[0];
        send(0, 8'h5A);
        send(0, 8'hC3);
        while (cyc < st_log[0][s0] + 180) @(negedge clk_40k);
        rst_a[0] = 1'b1;
        @(negedge clk_40k);
        chk("t4 bit_out after reset", 32'(bo_a[0]), 32'd1);
        chk("t4 din_rdy after reset", 32'(rdy_a[0]), 32'd1);
        chk("t4 busy after reset", 32'(busy_a[0]), 32'd0);
        chk("t4 tx_done after reset", 32'(done_a[0]), 32'd0);
        rst_a[0] = 1'b0;
        q0.delete();
        repeat (600) @(negedge clk_40k);
        chk("t4 no further frame", st_n[0], s0 + 1);
        chk("t4 no tx_done", dn_n[0], d0);

        // din_vld held high: one accept per din_rdy window
        s0   = st_n[0];
        d0   = dn_n[0];
        nacc = 0;
        din_a[0] = 8'h3C;
        vld_a[0] = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            if (rdy_a[0] === 1'b1) begin
                push(0, 8'h3C);
                nacc++;
            end
            @(negedge clk_40k);
        end
        vld_a[0] = 1'b0;
        chk("t5 accept count", nacc, 4);
        wait_done(0, d0 + 4, 2000);
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("t5 contiguous frame %0d", k), st_log[0][s0 + k], dn_log[0][d0 + k - 1]);
        end

        // 2000 baud instance
        send(2, 8'h81);
        wait_done(2, 1, 400);
        chk("t6 start latency", st_log[2][0], acc_cyc + 1);
        chk("t6 frame length", dn_log[2][0] - st_log[2][0], 200);

        repeat (50) @(negedge clk_40k);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stray line/busy/tx_done dut%0d", i), spur[i], 0);
            chk($sformatf("unsent bytes dut%0d", i), qsize(i), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
